fcp6_slave: RTL and testbench

Bus-side slave endpoint for the FCP6 two-bit serial bus, sitting directly downstream of the FCP6 master on the shared `data`/`ack`/`ctrl` wires. It decodes the 8-bit header and matches the 7-bit address. On a write it receives one data byte and hands it to local logic; on a read it serialises a local byte back to the master. It drives `ack` and the slave-owned `ctrl` codes, and tri-states every bus pin whenever it does not own it.

---
 rtl/fcp6_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_fcp6_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcp6_slave.sv
// fcp6_slave: slave endpoint on the FCP6 two-bit serial bus.
//   Decodes the 8-bit header (7-bit address + write flag) and matches SLAVE_ADDR.
//   A write receives one byte and hands it to local logic. A read serialises a
//   local byte back to the master. Bus pins are tri-stated when not owned.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   data[1:0]  inout  bus dibit (master: header/write data, slave: read data)
//   ack        inout  handshake (slave: 0 accept / 1 reject; master: 1 read received)
//   ctrl[1:0]  inout  01 master owns bus, 10 slave sending, 11 end of transfer
//   rx_ready   in     local logic can take a write byte
//   rd_data    in     byte returned on reads, captured in the address-ack cycle
//   wr_valid   out    one-cycle pulse per accepted write byte
//   wr_data    out    last accepted write byte
//   rd_done    out    one-cycle pulse when the master confirms a read
//   busy       out    high whenever the slave is not idle
//   timeout_err out   one-cycle pulse on a watchdog abort
//
// Build option: define FCP6_SLAVE_TIMEOUT_EN to enable the stall watchdog
// (TIMEOUT cycles). Without it timeout_err is tied to 0.

module fcp6_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h2A,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [1:0] data,
  inout  wire        ack,
  inout  wire  [1:0] ctrl,
  input  logic       rx_ready,
  input  logic [7:0] rd_data,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_done,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_WAIT, S_END
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rbyte_q, rbyte_d;
  logic [1:0] data_o_q, data_o_d;
  logic       data_en_q, data_en_d;
  logic [1:0] ctrl_o_q, ctrl_o_d;
  logic       ctrl_en_q, ctrl_en_d;
  logic       ack_o_q, ack_o_d;
  logic       ack_en_q, ack_en_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_done_q, rd_done_d;
  logic       busy_q, busy_d;

  logic shift_ok, shift_abort;

`ifdef FCP6_SLAVE_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic           ctrl_unk;
  logic [WDW-1:0] wd_q, wd_d;
  logic           tmo_q, tmo_d;

  // An undriven/unknown ctrl neither shifts nor aborts: the shifter stalls
  // and the watchdog decides.
  assign ctrl_unk    = $isunknown(ctrl);
  assign shift_ok    = !ctrl_unk && (ctrl == 2'b01);
  assign shift_abort = !ctrl_unk && (ctrl != 2'b01);
`else
  assign shift_ok    = (ctrl == 2'b01);
  assign shift_abort = !shift_ok;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rbyte_d    = rbyte_q;
    ack_o_d    = 1'b0;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    rd_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ctrl == 2'b01) begin
          state_d = S_HDR;
          cnt_d   = 2'd3;
        end
      end
      S_HDR, S_WR_DATA: begin
        if (shift_abort) begin
          state_d = S_IDLE;
        end else if (shift_ok) begin
          sh_d  = {sh_q[5:0], data};
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd0) begin
            // The ack value is decided on the last dibit so it can be driven
            // from a register in the very next cycle.
            if (state_q == S_HDR) begin
              state_d = S_ADDR_ACK;
              ack_o_d = (sh_d[7:1] != SLAVE_ADDR);
            end else begin
              state_d = S_WR_ACK;
              ack_o_d = !rx_ready;
              if (rx_ready) begin
                wr_valid_d = 1'b1;
                wr_data_d  = sh_d;
              end
            end
          end
        end
      end
      S_ADDR_ACK: begin
        // ack_o_q holds the reject decision made on entry.
        if (ack_o_q) begin
          state_d = S_IDLE;
        end else if (sh_q[0]) begin
          state_d = S_WR_DATA;
          cnt_d   = 2'd3;
        end else begin
          rbyte_d = rd_data;
          state_d = S_RD_DATA;
          cnt_d   = 2'd3;
        end
      end
      S_WR_ACK: begin
        if (ack_o_q) begin
          state_d = S_WR_DATA;
          cnt_d   = 2'd3;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_DATA: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (ack == 1'b1) begin
          state_d   = S_END;
          rd_done_d = 1'b1;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef FCP6_SLAVE_TIMEOUT_EN
    wd_d  = '0;
    tmo_d = 1'b0;
    if ((state_d == state_q) &&
        ((state_q == S_RD_WAIT) ||
         (((state_q == S_HDR) || (state_q == S_WR_DATA)) && ctrl_unk))) begin
      if (wd_q == WD_LAST) begin
        tmo_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end
`endif

    // Pin ownership follows the state being entered.
    data_en_d = (state_d == S_RD_DATA);
    ctrl_en_d = (state_d == S_RD_DATA) || (state_d == S_END);
    ctrl_o_d  = (state_d == S_END) ? 2'b11 : 2'b10;
    ack_en_d  = (state_d == S_ADDR_ACK) || (state_d == S_WR_ACK);
    busy_d    = (state_d != S_IDLE);
    unique case (cnt_d)
      2'd3: data_o_d = rbyte_d[7:6];
      2'd2: data_o_d = rbyte_d[5:4];
      2'd1: data_o_d = rbyte_d[3:2];
      default: data_o_d = rbyte_d[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rbyte_q    <= '0;
      data_o_q   <= '0;
      data_en_q  <= 1'b0;
      ctrl_o_q   <= '0;
      ctrl_en_q  <= 1'b0;
      ack_o_q    <= 1'b0;
      ack_en_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FCP6_SLAVE_TIMEOUT_EN
      wd_q       <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rbyte_q    <= rbyte_d;
      data_o_q   <= data_o_d;
      data_en_q  <= data_en_d;
      ctrl_o_q   <= ctrl_o_d;
      ctrl_en_q  <= ctrl_en_d;
      ack_o_q    <= ack_o_d;
      ack_en_q   <= ack_en_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_done_q  <= rd_done_d;
      busy_q     <= busy_d;
`ifdef FCP6_SLAVE_TIMEOUT_EN
      wd_q       <= wd_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign data = data_en_q ? data_o_q : 2'bzz;
  assign ctrl = ctrl_en_q ? ctrl_o_q : 2'bzz;
  assign ack  = ack_en_q  ? ack_o_q  : 1'bz;

  assign wr_valid = wr_valid_q;
  assign wr_data  = wr_data_q;
  assign rd_done  = rd_done_q;
  assign busy     = busy_q;

`ifdef FCP6_SLAVE_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
  // TIMEOUT only has meaning with the watchdog; it stays on the interface so
  // both builds accept the same parameter overrides.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_fcp6_slave.sv
module tb_fcp6_slave;

  localparam logic [6:0] ADDR = 7'h2A;
  localparam int         TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  tri1 [1:0] data;
  tri0 [1:0] ctrl;
  tri0       ack;
  logic       rx_ready;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_done, busy, timeout_err;

  // master-side drivers
  logic       m_data_en, m_ctrl_en, m_ack_en;
  logic [1:0] m_data, m_ctrl;
  logic       m_ack;
  assign data = m_data_en ? m_data : 2'bzz;
  assign ctrl = m_ctrl_en ? m_ctrl : 2'bzz;
  assign ack  = m_ack_en  ? m_ack  : 1'bz;

  fcp6_slave #(.SLAVE_ADDR(ADDR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .data(data), .ack(ack), .ctrl(ctrl),
    .rx_ready(rx_ready), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_done(rd_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // what the slave should be driving this cycle
  logic       s_data_en, s_ctrl_en, s_ack_en;
  logic [1:0] s_data, s_ctrl;
  logic       s_ack;
  // resolved expectations for this cycle
  logic [1:0] e_data, e_ctrl;
  logic       e_ack, e_busy, e_wv, e_rd, e_to;
  logic [7:0] e_wd;
  logic [7:0] model_wd;
  logic [7:0] rd_seen;
  logic       chk_en;
  int total = 0;
  int bad = 0;
  int wv_count = 0;
  int wv_base;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data",        {6'd0, data},        {6'd0, e_data});
      chk("ctrl",        {6'd0, ctrl},        {6'd0, e_ctrl});
      chk("ack",         {7'd0, ack},         {7'd0, e_ack});
      chk("busy",        {7'd0, busy},        {7'd0, e_busy});
      chk("wr_valid",    {7'd0, wr_valid},    {7'd0, e_wv});
      chk("wr_data",     wr_data,             e_wd);
      chk("rd_done",     {7'd0, rd_done},     {7'd0, e_rd});
      chk("timeout_err", {7'd0, timeout_err}, {7'd0, e_to});
      if (wr_valid) wv_count++;
    end
  end

  task automatic set_defaults();
    m_data_en = 1'b0; m_ctrl_en = 1'b0; m_ack_en = 1'b0;
    m_data = 2'b00; m_ctrl = 2'b00; m_ack = 1'b0;
    s_data_en = 1'b0; s_ctrl_en = 1'b0; s_ack_en = 1'b0;
    s_data = 2'b00; s_ctrl = 2'b00; s_ack = 1'b0;
    e_busy = 1'b0; e_wv = 1'b0; e_rd = 1'b0; e_to = 1'b0;
    rst = 1'b0;
    rx_ready = 1'($urandom_range(0, 1));
    rd_data  = 8'($urandom);
  endtask

  // Finish describing the current cycle, let it run, then start the next one.
  task automatic cyc();
    e_data = s_data_en ? s_data : (m_data_en ? m_data : 2'b11);
    e_ctrl = s_ctrl_en ? s_ctrl : (m_ctrl_en ? m_ctrl : 2'b00);
    e_ack  = s_ack_en  ? s_ack  : (m_ack_en  ? m_ack  : 1'b0);
    e_wd   = model_wd;
    @(posedge clk);
    #1;
    set_defaults();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_dibit(input logic [1:0] d);
    m_ctrl_en = 1'b1; m_ctrl = 2'b01; m_data_en = 1'b1; m_data = d; e_busy = 1'b1;
  endtask

  // wr: 1 = write. nrej: rejected write attempts before acceptance.
  // wt: read wait cycles before master ack; negative = master never acks.
  task automatic xfer(input logic [6:0] addr, input logic wr, input logic [7:0] bv,
                      input int nrej, input int wt);
    logic [7:0] hdr;
    logic       hit;
    hdr = {addr, wr};
    hit = (addr == ADDR);
    m_ctrl_en = 1'b1; m_ctrl = 2'b01;
    cyc();
    for (int i = 3; i >= 0; i--) begin
      send_dibit(hdr[2*i +: 2]);
      cyc();
    end
    e_busy = 1'b1; s_ack_en = 1'b1; s_ack = !hit;
    if (!wr) rd_data = bv;
    cyc();
    if (!hit) return;
    if (wr) begin
      for (int a = 0; a <= nrej; a++) begin
        for (int i = 3; i >= 0; i--) begin
          send_dibit(bv[2*i +: 2]);
          if (i == 0) rx_ready = (a == nrej);
          cyc();
        end
        m_ctrl_en = 1'b1; m_ctrl = 2'b11; e_busy = 1'b1;
        s_ack_en = 1'b1; s_ack = (a != nrej);
        if (a == nrej) begin
          model_wd = bv;
          e_wv = 1'b1;
        end
        cyc();
      end
    end else begin
      rd_seen = 8'h00;
      for (int i = 3; i >= 0; i--) begin
        s_data_en = 1'b1; s_data = bv[2*i +: 2];
        s_ctrl_en = 1'b1; s_ctrl = 2'b10; e_busy = 1'b1;
        rd_seen = {rd_seen[5:0], data};
        cyc();
      end
      if (wt < 0) begin
        for (int k = 0; k < TMO; k++) begin
          e_busy = 1'b1;
          cyc();
        end
        e_to = 1'b1;
        cyc();
      end else begin
        for (int k = 0; k < wt; k++) begin
          e_busy = 1'b1; m_ack_en = 1'($urandom_range(0, 1)); m_ack = 1'b0;
          cyc();
        end
        e_busy = 1'b1; m_ack_en = 1'b1; m_ack = 1'b1;
        cyc();
        e_busy = 1'b1; s_ctrl_en = 1'b1; s_ctrl = 2'b11; e_rd = 1'b1;
        cyc();
      end
    end
  endtask

  // Header aborted by ctrl leaving 01 on the second header dibit.
  task automatic hdr_abort(input logic [1:0] bad_ctrl);
    m_ctrl_en = 1'b1; m_ctrl = 2'b01;
    cyc();
    send_dibit(2'b10);
    cyc();
    send_dibit(2'b10);
    m_ctrl = bad_ctrl;
    cyc();
  endtask

  // Reset asserted during header cycle 3.
  task automatic reset_mid();
    logic [7:0] hdr;
    hdr = {ADDR, 1'b1};
    m_ctrl_en = 1'b1; m_ctrl = 2'b01;
    cyc();
    send_dibit(hdr[7:6]);
    cyc();
    send_dibit(hdr[5:4]);
    cyc();
    send_dibit(hdr[3:2]);
    rst = 1'b1;
    cyc();
    model_wd = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    int         kind;
    chk_en   = 1'b0;
    model_wd = 8'h00;
    rd_seen  = 8'h00;
    set_defaults();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    idle(2);

    // write A5 accepted first time
    wv_base = wv_count;
    xfer(ADDR, 1'b1, 8'hA5, 0, 0);
    chk("wr_data_A5", wr_data, 8'hA5);
    chk("wr_pulses_A5", 8'(wv_count - wv_base), 8'd1);
    idle(1);

    // read 3C, master acks after two wait cycles
    xfer(ADDR, 1'b0, 8'h3C, 0, 2);
    chk("rd_serial_3C", rd_seen, 8'h3C);
    idle(1);

    // address miss
    wv_base = wv_count;
    xfer(7'h15, 1'b1, 8'hC3, 0, 0);
    idle(2);
    chk("miss_pulses", 8'(wv_count - wv_base), 8'd0);

    // retry once, then accept
    wv_base = wv_count;
    xfer(ADDR, 1'b1, 8'h5A, 1, 0);
    chk("retry_pulses", 8'(wv_count - wv_base), 8'd1);
    chk("wr_data_5A", wr_data, 8'h5A);
    idle(1);

    // reset in mid-header, then a clean write
    reset_mid();
    idle(2);
    chk("wr_data_after_rst", wr_data, 8'h00);
    xfer(ADDR, 1'b1, 8'h96, 0, 0);
    idle(1);

    hdr_abort(2'b11);
    idle(1);
    hdr_abort(2'b00);

`ifdef FCP6_SLAVE_TIMEOUT_EN
    idle(1);
    xfer(ADDR, 1'b0, 8'hE1, 0, -1);
    idle(2);
`endif

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1: xfer(ADDR, 1'b1, 8'($urandom), int'($urandom_range(0, 2)), 0);
        2:    xfer(ADDR, 1'b0, 8'($urandom), 0, int'($urandom_range(0, 4)));
        3: begin
          a = 7'($urandom);
          while (a == ADDR) a = 7'($urandom);
          xfer(a, 1'($urandom_range(0, 1)), 8'($urandom), 0, 0);
        end
        default: hdr_abort(2'b11);
      endcase
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
